// File: rtl/mavg_pkg.sv
// mavg_pkg: shared sizing and rounding helpers for the multichannel moving-average filter.
// No ports. Provides the accumulator width, the channel-index width and the
// rounding constant added ahead of the final divide-by-N shift.
package mavg_pkg;

    // Sum of 2^log2_n samples of width bits fits in width+log2_n bits.
    function automatic int acc_width(input int width, input int log2_n);
        return width + log2_n;
    endfunction

    // A one-channel build still carries a 1-bit channel field.
    function automatic int chan_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

    // Half an LSB of the averaged result, for round-half-up.
    function automatic int round_const(input int log2_n);
        return 1 << (log2_n - 1);
    endfunction

endpackage

// File: rtl/mavg_history.sv
// mavg_history: per-channel N-deep circular sample buffer with write pointer
// and saturating fill counter.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous flush of buffer, pointer and counter
//   wr_en         store wr_data at the current pointer and advance it
//   wr_data       incoming sample
//   old_data      sample about to be overwritten (combinational read)
//   primed        buffer has received at least N samples
module mavg_history #(
    parameter int WIDTH  = 24,
    parameter int LOG2_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] old_data,
    output logic             primed
);

    localparam int N = 1 << LOG2_N;
    localparam logic [LOG2_N:0] CNT_FULL = (LOG2_N + 1)'(N);

    logic [WIDTH-1:0]  hist_q [N];
    logic [LOG2_N-1:0] ptr_q;
    logic [LOG2_N:0]   cnt_q;

    assign old_data = hist_q[ptr_q];
    assign primed   = (cnt_q == CNT_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) hist_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) hist_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (wr_en) begin
            hist_q[ptr_q] <= wr_data;
            // Pointer is exactly LOG2_N bits, so it wraps modulo N naturally.
            ptr_q <= ptr_q + 1'b1;
            if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/multichannel_avg_filter.sv
// multichannel_avg_filter: N-tap boxcar average over time-multiplexed channels.
// Each channel keeps its own history buffer and full-precision running sum.
// Optional feature macro: MAVG_ROUND_EN (round-half-up instead of floor).
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   clear                  synchronous flush of all channel state
//   in_valid/in_ready      input handshake; in_chan selects channel, in_data sample
//   out_valid/out_ready    output handshake; out_chan, out_data averaged result
//   primed                 per-channel window-full flags
//   chan_err               sticky: out-of-range in_chan was accepted
module multichannel_avg_filter
    import mavg_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int LOG2_N   = 4,
    parameter int CHANNELS = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [chan_width(CHANNELS)-1:0]   in_chan,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [chan_width(CHANNELS)-1:0]   out_chan,
    output logic [WIDTH-1:0]                  out_data,
    output logic [CHANNELS-1:0]               primed,
    output logic                              chan_err
);

    localparam int AW = acc_width(WIDTH, LOG2_N);
    localparam int CW = chan_width(CHANNELS);
    localparam logic [CW:0] CH_LIM = (CW + 1)'(CHANNELS);

    logic signed [AW-1:0] acc_q [CHANNELS];
    logic [WIDTH-1:0]     old_data [CHANNELS];
    logic [CHANNELS-1:0]  wr_en;

    logic                 out_valid_q;
    logic [CW-1:0]        out_chan_q;
    logic [WIDTH-1:0]     out_data_q;
    logic                 chan_err_q;

    logic                 accept;
    logic                 chan_ok;
    logic                 fire;
    logic signed [AW-1:0] acc_sel;
    logic [WIDTH-1:0]     old_sel;
    logic signed [AW-1:0] acc_d;
    logic signed [AW:0]   acc_rnd;

    // rst term keeps the block from advertising space while held in reset.
    assign in_ready = (!out_valid_q || out_ready) && !clear && !rst;
    assign accept   = in_valid && in_ready;
    assign chan_ok  = ({1'b0, in_chan} < CH_LIM);
    assign fire     = accept && chan_ok;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        mavg_history #(
            .WIDTH  (WIDTH),
            .LOG2_N (LOG2_N)
        ) u_hist (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .wr_en    (wr_en[c]),
            .wr_data  (in_data),
            .old_data (old_data[c]),
            .primed   (primed[c])
        );
    end

    // Loop-based select avoids indexing past CHANNELS with a bad in_chan.
    always_comb begin
        acc_sel = '0;
        old_sel = '0;
        wr_en   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_chan == CW'(c)) begin
                acc_sel  = acc_q[c];
                old_sel  = old_data[c];
                wr_en[c] = fire;
            end
        end
    end

    always_comb begin
        acc_d = acc_sel + {{LOG2_N{in_data[WIDTH-1]}}, in_data}
                        - {{LOG2_N{old_sel[WIDTH-1]}}, old_sel};
        // One guard bit so the rounding offset cannot wrap a full-scale sum.
`ifdef MAVG_ROUND_EN
        acc_rnd = $signed({acc_d[AW-1], acc_d}) + (AW + 1)'(round_const(LOG2_N));
`else
        acc_rnd = $signed({acc_d[AW-1], acc_d});
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            chan_err_q  <= 1'b0;
        end else if (clear) begin
            for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (fire) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (wr_en[c]) acc_q[c] <= acc_d;
                end
                out_valid_q <= 1'b1;
                out_chan_q  <= in_chan;
                out_data_q  <= WIDTH'(acc_rnd >>> LOG2_N);
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && !chan_ok) chan_err_q <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_data  = out_data_q;
    assign chan_err  = chan_err_q;

endmodule
